// File: rtl/butterfly_array_if.sv
// Beat-level streaming bus of the butterfly engine: input beat, output beat and
// their valid/ready handshakes. The engine takes the slave view.
interface butterfly_array_if #(
    parameter int LANES = 4,
    parameter int DW    = 12,
    parameter int TAGW  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [LANES*DW-1:0]   in_a;
    logic [LANES*DW-1:0]   in_b;
    logic [LANES*DW-1:0]   in_w;
    logic [TAGW-1:0]       in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_e;
    logic [LANES*DW-1:0]   out_o;
    logic [TAGW-1:0]       out_tag;
    logic [LANES-1:0]      out_err;

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        output in_ready, out_valid, out_e, out_o, out_tag, out_err
    );

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, in_tag, out_ready,
        input  in_ready, out_valid, out_e, out_o, out_tag, out_err
    );
endinterface

// File: rtl/butterfly_array.sv
// Multi-lane pipelined CT / GS / pointwise-multiply butterfly over Z_Q with
// Barrett reduction and a globally stalled valid/ready pipeline.
module butterfly_array #(
    parameter int LANES = 4,
    parameter int DW    = 12,
    parameter int Q     = 3329,
    parameter int TAGW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    butterfly_array_if.slave  bf
);
    localparam int PW = 2 * DW;
    localparam logic [DW-1:0] QD = DW'(Q);
    localparam logic [DW:0]   QX = (DW+1)'(Q);
    localparam logic [PW-1:0] QP = PW'(Q);
    // Barrett constant floor(2^PW / Q); with x < 2^PW the quotient estimate is short by at most one
    localparam logic [PW:0]   MU = (PW+1)'((65'd1 << PW) / 65'(Q));

    typedef enum logic [1:0] {MODE_CT, MODE_GS, MODE_PWM, MODE_RSV} mode_e;
    typedef logic [LANES-1:0][DW-1:0] lane_t;
    typedef logic [LANES-1:0][PW-1:0] prod_t;

    function automatic logic [DW-1:0] addMod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= QX) ? DW'(s - QX) : DW'(s);
    endfunction

    function automatic logic [DW-1:0] subMod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] d;
        d = {1'b0, x} - {1'b0, y};
        return (x < y) ? DW'(d + QX) : DW'(d);
    endfunction

    function automatic logic [PW-1:0] barrettQuot(input logic [PW-1:0] x);
        logic [2*PW:0] m;
        m = (2*PW+1)'(x) * (2*PW+1)'(MU);
        return PW'(m >> PW);
    endfunction

    function automatic logic [DW-1:0] barrettRem(input logic [PW-1:0] x, input logic [PW-1:0] qh);
        logic [PW-1:0] r;
        r = x - qh * QP;
        return (r >= QP) ? DW'(r - QP) : DW'(r);
    endfunction

    logic stall, adv;
    logic v1_q, v2_q, v3_q, v4_q, v5_q;
    mode_e m1_q, m2_q, m3_q, m4_q, m1_d;
    logic [TAGW-1:0] t1_q, t2_q, t3_q, t4_q, t5_q;
    logic [LANES-1:0] err1_q, err2_q, err3_q, err4_q, err5_q, err1_d;
    lane_t a1_q, b1_q, w1_q, aux2_q, aux3_q, aux4_q, rx4_q, ry4_q, e5_q, o5_q;
    lane_t aux2_d, rx4_d, ry4_d, e5_d, o5_d;
    prod_t px2_q, py2_q, px3_q, py3_q, qx3_q, qy3_q;
    prod_t px2_d, py2_d, qx3_d, qy3_d;

    assign stall        = v5_q && !bf.out_ready;
    assign adv          = !stall;
    assign bf.in_ready  = adv;
    assign bf.out_valid = v5_q;
    assign bf.out_e     = e5_q;
    assign bf.out_o     = o5_q;
    assign bf.out_tag   = t5_q;
    assign bf.out_err   = err5_q;

    // Reserved mode is folded into CT at capture so later stages only see three modes
    always_comb begin
        m1_d   = MODE_CT;
        err1_d = '0;
        aux2_d = '0;
        px2_d  = '0;
        py2_d  = '0;
        qx3_d  = '0;
        qy3_d  = '0;
        rx4_d  = '0;
        ry4_d  = '0;
        e5_d   = '0;
        o5_d   = '0;
        if (bf.in_mode == MODE_GS) m1_d = MODE_GS;
        else if (bf.in_mode == MODE_PWM) m1_d = MODE_PWM;
        for (int i = 0; i < LANES; i++) begin
            err1_d[i] = (bf.in_mode == MODE_RSV) || (bf.in_a[i*DW +: DW] >= QD) ||
                        (bf.in_b[i*DW +: DW] >= QD) || (bf.in_w[i*DW +: DW] >= QD);
            aux2_d[i] = (m1_q == MODE_GS) ? addMod(a1_q[i], b1_q[i]) : a1_q[i];
            px2_d[i]  = PW'((m1_q == MODE_PWM) ? a1_q[i] : b1_q[i]) * PW'(w1_q[i]);
            py2_d[i]  = PW'((m1_q == MODE_GS) ? subMod(a1_q[i], b1_q[i]) : b1_q[i]) * PW'(w1_q[i]);
            qx3_d[i]  = barrettQuot(px2_q[i]);
            qy3_d[i]  = barrettQuot(py2_q[i]);
            rx4_d[i]  = barrettRem(px3_q[i], qx3_q[i]);
            ry4_d[i]  = barrettRem(py3_q[i], qy3_q[i]);
            case (m4_q)
                MODE_GS: begin
                    e5_d[i] = aux4_q[i];
                    o5_d[i] = ry4_q[i];
                end
                MODE_PWM: begin
                    e5_d[i] = rx4_q[i];
                    o5_d[i] = ry4_q[i];
                end
                default: begin
                    e5_d[i] = addMod(aux4_q[i], rx4_q[i]);
                    o5_d[i] = subMod(aux4_q[i], rx4_q[i]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v1_q, v2_q, v3_q, v4_q, v5_q} <= '0;
            {m1_q, m2_q, m3_q, m4_q} <= {MODE_CT, MODE_CT, MODE_CT, MODE_CT};
            {t1_q, t2_q, t3_q, t4_q, t5_q} <= '0;
            {err1_q, err2_q, err3_q, err4_q, err5_q} <= '0;
            {a1_q, b1_q, w1_q, aux2_q, aux3_q, aux4_q} <= '0;
            {rx4_q, ry4_q, e5_q, o5_q} <= '0;
            {px2_q, py2_q, px3_q, py3_q, qx3_q, qy3_q} <= '0;
        end else if (adv) begin
            v1_q   <= bf.in_valid;
            m1_q   <= m1_d;
            t1_q   <= bf.in_tag;
            err1_q <= err1_d;
            a1_q   <= bf.in_a;
            b1_q   <= bf.in_b;
            w1_q   <= bf.in_w;
            v2_q   <= v1_q;
            m2_q   <= m1_q;
            t2_q   <= t1_q;
            err2_q <= err1_q;
            aux2_q <= aux2_d;
            px2_q  <= px2_d;
            py2_q  <= py2_d;
            v3_q   <= v2_q;
            m3_q   <= m2_q;
            t3_q   <= t2_q;
            err3_q <= err2_q;
            aux3_q <= aux2_q;
            px3_q  <= px2_q;
            py3_q  <= py2_q;
            qx3_q  <= qx3_d;
            qy3_q  <= qy3_d;
            v4_q   <= v3_q;
            m4_q   <= m3_q;
            t4_q   <= t3_q;
            err4_q <= err3_q;
            aux4_q <= aux3_q;
            rx4_q  <= rx4_d;
            ry4_q  <= ry4_d;
            v5_q   <= v4_q;
            t5_q   <= t4_q;
            err5_q <= err4_q;
            e5_q   <= e5_d;
            o5_q   <= o5_d;
        end
    end
endmodule
